// File: rtl/column_sum_accumulator_pkg.sv
// Shared constants and state encoding for the column sum accumulator.
// The column counts are summed with a serial carry across columns.
package column_sum_accumulator_pkg;

  localparam int DEF_NCOL     = 16;
  localparam int DEF_RES_W    = DEF_NCOL + 4;
  localparam int FLUSH_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/column_sum_accumulator_adder15_4.sv
// 15:4 column compressor: the number of set bits in one 15-bit
// partial-product column.
module adder15_4 (
  input  logic [14:0] col,
  output logic [3:0]  cnt
);

  always_comb begin
    cnt = 4'd0;
    for (int i = 0; i < 15; i++) begin
      cnt = cnt + {3'd0, col[i]};
    end
  end

endmodule

// File: rtl/column_sum_accumulator.sv
// Sums weighted popcounts of LSB-first partial-product columns into one
// exact binary total and hands it to the accumulator stage.
module column_sum_accumulator
  import column_sum_accumulator_pkg::*;
#(
  parameter int NCOL  = DEF_NCOL,
  parameter int RES_W = NCOL + 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [14:0]      in_col,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_sum,
  output logic             out_ovf,
  output state_t           dbg_state
);

  localparam int COL_W = $clog2(NCOL + 4);
  localparam logic [COL_W-1:0] LAST_IDX  = COL_W'(NCOL - 1);
  localparam logic [1:0]       FLUSH_END = 2'(FLUSH_CYCLES - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; ready and valid are decoded from registered state only,
  // so neither depends combinationally on the other side's signal.

  state_t             state, state_nx;
  logic [COL_W-1:0]   col_idx;
  logic [3:0]         carry;
  logic [RES_W-1:0]   result;
  logic [1:0]         flush_cnt;
  logic               ovf_r;

  logic [3:0]         cnt;
  logic [4:0]         s;
  logic               accept;
  logic               frame_end;
  logic               out_fire;

  adder15_4 u_adder15_4 (
    .col (in_col),
    .cnt (cnt)
  );

  assign s         = {1'b0, carry} + {1'b0, cnt};
  assign accept    = in_valid && in_ready;
  assign frame_end = in_last || (col_idx == LAST_IDX);
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_ACC;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid && frame_end) state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_cnt == FLUSH_END) state_nx = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = ST_ACC;
      end
      default: state_nx = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_idx   <= '0;
      carry     <= '0;
      result    <= '0;
      flush_cnt <= '0;
      ovf_r     <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            result[col_idx] <= s[0];
            carry           <= s[4:1];
            col_idx         <= col_idx + 1'b1;
            flush_cnt       <= '0;
            ovf_r           <= (col_idx == LAST_IDX) && !in_last;
          end
        end
        ST_FLUSH: begin
          // Drain the remaining carry one bit per edge above the last column.
          result[col_idx] <= carry[0];
          carry           <= carry >> 1;
          col_idx         <= col_idx + 1'b1;
          flush_cnt       <= flush_cnt + 1'b1;
        end
        ST_HOLD: begin
          if (out_fire) begin
            result  <= '0;
            carry   <= '0;
            col_idx <= '0;
            ovf_r   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum   = out_valid ? result : '0;
  assign out_ovf   = out_valid && ovf_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_column_sum_accumulator.sv
// Bench for column_sum_accumulator: directed and random frames checked
// against a weighted-popcount reference model.
module tb_column_sum_accumulator;
  import column_sum_accumulator_pkg::*;

  localparam int NC = DEF_NCOL;
  localparam int RW = NC + 4;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [14:0]   in_col;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_sum;
  logic          out_ovf;
  state_t        dbg_state;

  logic [14:0]   frame_q[$];
  logic [RW:0]   exp_q[$];
  int            checks;
  int            errors;

  column_sum_accumulator dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_col    (in_col),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: total = sum of popcount(col_k) * 2^k; overflow when a full
  // NC-column frame arrives without a last marker.
  function automatic logic [RW:0] model(input logic use_last);
    longint total = 0;
    logic   ovf;
    for (int k = 0; k < frame_q.size(); k++)
      total += longint'($countones(frame_q[k])) * (longint'(1) << k);
    ovf = !use_last && (frame_q.size() == NC);
    return {ovf, RW'(total)};
  endfunction

  // driver tasks
  task automatic send_col(input logic [14:0] c, input logic l, input int bubble);
    int guard = 0;
    repeat (bubble) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_col   = c;
    in_last  = l;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL send_accept: in_ready stayed 0 for %0d cycles, required 1", guard);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits for the result, checks latency/value, holds it for hs_delay
  // cycles (optionally driving in_valid) and then completes the handshake.
  task automatic collect(input int hs_delay, input logic drive_junk);
    int          lat;
    logic [RW:0] exp;
    exp = exp_q.pop_front();
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != FLUSH_CYCLES) begin
      errors++;
      $display("FAIL latency: out_valid after %0d edges, required %0d", lat, FLUSH_CYCLES);
    end
    if (lat == 0) return;
    checks++;
    if (out_sum !== exp[RW-1:0]) begin
      errors++;
      $display("FAIL out_sum: got %0d, required %0d", out_sum, exp[RW-1:0]);
    end
    checks++;
    if (out_ovf !== exp[RW]) begin
      errors++;
      $display("FAIL out_ovf: got %0b, required %0b", out_ovf, exp[RW]);
    end
    for (int i = 0; i < hs_delay; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== exp[RW-1:0]) begin
        errors++;
        $display("FAIL hold_stable: valid=%0b ready=%0b sum=%0d, required 1 0 %0d",
                 out_valid, in_ready, out_sum, exp[RW-1:0]);
      end
      in_valid = drive_junk;
      in_col   = 15'($urandom_range(0, 32767));
      in_last  = drive_junk;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_handshake: valid=%0b ready=%0b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic run_frame(input logic use_last, input int bubble_max,
                           input int hs_delay, input logic drive_junk);
    exp_q.push_back(model(use_last));
    for (int k = 0; k < frame_q.size(); k++)
      send_col(frame_q[k], use_last && (k == frame_q.size() - 1),
               $urandom_range(0, bubble_max));
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_last: in_ready=%0b, required 0", in_ready);
    end
    collect(hs_delay, drive_junk);
  endtask

  task automatic fill(input int n, input logic [14:0] c);
    frame_q.delete();
    for (int k = 0; k < n; k++) frame_q.push_back(c);
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 ||
        out_ovf !== 1'b0 || dbg_state !== ST_ACC) begin
      errors++;
      $display("FAIL %s: ready=%0b valid=%0b sum=%0d ovf=%0b state=%0d, required 1 0 0 0 0",
               tag, in_ready, out_valid, out_sum, out_ovf, dbg_state);
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle("reset_state");
  endtask

  task automatic test_single();
    fill(1, 15'h7FFF);
    run_frame(1'b1, 0, 0, 1'b0);
  endtask

  task automatic test_two();
    frame_q.delete();
    frame_q.push_back(15'h0007);
    frame_q.push_back(15'h7FFF);
    run_frame(1'b1, 0, 0, 1'b0);
  endtask

  task automatic test_full_frame();
    fill(NC, 15'h7FFF);
    run_frame(1'b1, 0, 0, 1'b0);
    run_frame(1'b1, 2, 1, 1'b0);
  endtask

  task automatic test_overflow();
    fill(NC, 15'h0001);
    run_frame(1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    frame_q.delete();
    frame_q.push_back(15'h1234);
    frame_q.push_back(15'h0F0F);
    run_frame(1'b1, 0, 10, 1'b1);
  endtask

  task automatic test_reset_midframe();
    for (int k = 0; k < 3; k++) send_col(15'h7FFF, 1'b0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("reset_midframe");
    fill(1, 15'h0002);
    run_frame(1'b1, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      frame_q.delete();
      for (int k = 0; k < f + 2; k++) frame_q.push_back(15'($urandom_range(0, 32767)));
      run_frame(1'b1, 0, 0, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      int   n;
      logic use_last;
      n        = $urandom_range(1, NC);
      use_last = (n != NC) || ($urandom_range(0, 1) == 1);
      frame_q.delete();
      for (int k = 0; k < n; k++) frame_q.push_back(15'($urandom_range(0, 32767)));
      run_frame(use_last, 2, $urandom_range(0, 3), 1'(($urandom_range(0, 1))));
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_col    = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_two();
    test_full_frame();
    test_overflow();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
